// File: rtl/restoring_divider_pkg.sv
// Shared sizing and state encoding for the sequential restoring divider.
package restoring_divider_pkg;

  localparam int DIV_WIDTH = 4;
  localparam int DIV_CNT_W = $clog2(DIV_WIDTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/restoring_divider_div_trial_sub.sv
// Combinational ripple subtractor, WIDTH+1 bits: t = rs - d, borrow = final borrow out.
module div_trial_sub #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH:0] rs,
  input  logic [WIDTH:0] d,
  output logic [WIDTH:0] t,
  output logic           borrow
);

  logic bw_s;

  // Bit-serial borrow chain, one full subtractor per bit.
  always_comb begin
    t    = {(WIDTH + 1){1'b0}};
    bw_s = 1'b0;
    for (int i = 0; i <= WIDTH; i++) begin
      t[i] = rs[i] ^ d[i] ^ bw_s;
      bw_s = (~rs[i] & d[i]) | (~(rs[i] ^ d[i]) & bw_s);
    end
    borrow = bw_s;
  end

endmodule

// File: rtl/restoring_divider.sv
// Unsigned sequential restoring divider: one quotient bit per clock, MSB first,
// start/done handshake, results held in output registers until the next done.
module restoring_divider
  import restoring_divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  div_state_e       state_r, state_nxt_s;
  logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
  logic [WIDTH-1:0] r_r, r_nxt_s;
  logic [WIDTH-1:0] q_r, q_nxt_s;
  logic [WIDTH-1:0] d_r, d_nxt_s;
  logic             dz_r, dz_nxt_s;

  logic             busy_r, busy_nxt_s;
  logic             done_r, done_nxt_s;
  logic [WIDTH-1:0] quotient_r, quotient_nxt_s;
  logic [WIDTH-1:0] remainder_r, remainder_nxt_s;
  logic             dbz_r, dbz_nxt_s;

  logic [WIDTH:0]   rs_s;
  logic [WIDTH:0]   t_s;
  logic             borrow_s;
  logic             fits_s;

  // The partial remainder always stays below the divisor, so only WIDTH bits
  // of R are ever non-zero; the shifted value Rs needs the extra bit.
  assign rs_s = {r_r, q_r[WIDTH-1]};

  div_trial_sub #(
    .WIDTH (WIDTH)
  ) u_trial_sub (
    .rs     (rs_s),
    .d      ({1'b0, d_r}),
    .t      (t_s),
    .borrow (borrow_s)
  );

  // Sign bit and ripple borrow agree; either one marks a failed trial.
  assign fits_s = ~(t_s[WIDTH] | borrow_s);

  // Next-state, datapath and output-register update logic.
  always_comb begin
    state_nxt_s     = state_r;
    cnt_nxt_s       = cnt_r;
    r_nxt_s         = r_r;
    q_nxt_s         = q_r;
    d_nxt_s         = d_r;
    dz_nxt_s        = dz_r;
    done_nxt_s      = 1'b0;
    quotient_nxt_s  = quotient_r;
    remainder_nxt_s = remainder_r;
    dbz_nxt_s       = dbz_r;

    case (state_r)
      ST_IDLE: begin
        // The done-high cycle is already IDLE; a start there is still refused.
        if (start && !done_r) begin
          d_nxt_s   = divisor;
          q_nxt_s   = dividend;
          r_nxt_s   = {WIDTH{1'b0}};
          cnt_nxt_s = CNT_W'(WIDTH);
          dz_nxt_s  = (divisor == {WIDTH{1'b0}});
          if (divisor == {WIDTH{1'b0}}) begin
            state_nxt_s = ST_DONE;
          end else begin
            state_nxt_s = ST_CALC;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end

      ST_CALC: begin
        if (fits_s) begin
          r_nxt_s = t_s[WIDTH-1:0];
          q_nxt_s = {q_r[WIDTH-2:0], 1'b1};
        end else begin
          r_nxt_s = rs_s[WIDTH-1:0];
          q_nxt_s = {q_r[WIDTH-2:0], 1'b0};
        end
        cnt_nxt_s = cnt_r - CNT_W'(1);
        if (cnt_r == CNT_W'(1)) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_CALC;
        end
      end

      ST_DONE: begin
        done_nxt_s = 1'b1;
        dbz_nxt_s  = dz_r;
        if (dz_r) begin
          quotient_nxt_s  = {WIDTH{1'b1}};
          remainder_nxt_s = q_r;
        end else begin
          quotient_nxt_s  = q_r;
          remainder_nxt_s = r_r;
        end
        state_nxt_s = ST_IDLE;
      end

      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase

    busy_nxt_s = (state_nxt_s == ST_CALC) || (state_nxt_s == ST_DONE);
  end

  // State, datapath and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      cnt_r       <= {CNT_W{1'b0}};
      r_r         <= {WIDTH{1'b0}};
      q_r         <= {WIDTH{1'b0}};
      d_r         <= {WIDTH{1'b0}};
      dz_r        <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      quotient_r  <= {WIDTH{1'b0}};
      remainder_r <= {WIDTH{1'b0}};
      dbz_r       <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      cnt_r       <= cnt_nxt_s;
      r_r         <= r_nxt_s;
      q_r         <= q_nxt_s;
      d_r         <= d_nxt_s;
      dz_r        <= dz_nxt_s;
      busy_r      <= busy_nxt_s;
      done_r      <= done_nxt_s;
      quotient_r  <= quotient_nxt_s;
      remainder_r <= remainder_nxt_s;
      dbz_r       <= dbz_nxt_s;
    end
  end

  assign busy        = busy_r;
  assign done        = done_r;
  assign quotient    = quotient_r;
  assign remainder   = remainder_r;
  assign div_by_zero = dbz_r;

endmodule

// File: tb/tb_restoring_divider.sv
// Directed and exhaustive checks for the 4-bit restoring divider.
module tb_restoring_divider;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] dividend;
  logic [3:0] divisor;
  logic       busy;
  logic       done;
  logic [3:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;

  int checks;
  int failures;
  int lat;
  int nbusy;
  int ndone;

  restoring_divider #(
    .WIDTH (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one operation; return edges from accepting edge to the done sample,
  // and the number of busy samples before done.
  task automatic do_div(input logic [3:0] a, input logic [3:0] b,
                        output int lat_o, output int nbusy_o);
    @(negedge clk);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(negedge clk);
    start   = 1'b0;
    lat_o   = 0;
    nbusy_o = 0;
    while (!done && lat_o < 20) begin
      if (busy) nbusy_o++;
      @(negedge clk);
      lat_o++;
    end
    if (!done) check("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = 4'd0;
    divisor  = 4'd0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_q", 32'(quotient), 32'd0);
    check("rst_r", 32'(remainder), 32'd0);
    check("rst_dbz", 32'(div_by_zero), 32'd0);
    rst_n = 1'b1;

    // 13/3: done five edges after acceptance, busy for five cycles
    do_div(4'd13, 4'd3, lat, nbusy);
    check("t1_latency", 32'(lat), 32'd5);
    check("t1_busy_cycles", 32'(nbusy), 32'd5);
    check("t1_busy_at_done", 32'(busy), 32'd0);
    check("t1_q", 32'(quotient), 32'd4);
    check("t1_r", 32'(remainder), 32'd1);
    check("t1_dbz", 32'(div_by_zero), 32'd0);
    @(negedge clk);
    check("t1_done_pulse", 32'(done), 32'd0);
    check("t1_q_hold", 32'(quotient), 32'd4);

    do_div(4'd15, 4'd1, lat, nbusy);
    check("t2_15_1", {24'd0, quotient, remainder}, {24'd0, 4'd15, 4'd0});
    do_div(4'd2, 4'd7, lat, nbusy);
    check("t2_2_7", {24'd0, quotient, remainder}, {24'd0, 4'd0, 4'd2});
    do_div(4'd15, 4'd15, lat, nbusy);
    check("t2_15_15", {24'd0, quotient, remainder}, {24'd0, 4'd1, 4'd0});

    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        logic [8:0] exp_v;
        do_div(4'(a), 4'(b), lat, nbusy);
        if (b == 0) exp_v = {1'b1, 4'hF, 4'(a)};
        else        exp_v = {1'b0, 4'(a / b), 4'(a % b)};
        check($sformatf("sweep_%0d_%0d", a, b),
              {23'd0, div_by_zero, quotient, remainder}, {23'd0, exp_v});
      end
    end

    // 9/0: straight to DONE, done one edge after acceptance
    do_div(4'd9, 4'd0, lat, nbusy);
    check("t3_latency", 32'(lat), 32'd1);
    check("t3_q", 32'(quotient), 32'hF);
    check("t3_r", 32'(remainder), 32'd9);
    check("t3_dbz", 32'(div_by_zero), 32'd1);
    do_div(4'd8, 4'd2, lat, nbusy);
    check("t3_follow", {23'd0, div_by_zero, quotient, remainder}, {23'd0, 1'b0, 4'd4, 4'd0});

    // 12/5 with stray 7/7 starts during CALC, DONE and the done-high cycle
    @(negedge clk);
    start = 1'b1; dividend = 4'd12; divisor = 4'd5;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        check("t4_result", {24'd0, quotient, remainder}, {24'd0, 4'd2, 4'd2});
      end
      if (k == 1 || k == 4 || k == 5) begin
        start = 1'b1; dividend = 4'd7; divisor = 4'd7;
      end else begin
        start = 1'b0;
      end
    end
    check("t4_done_count", 32'(ndone), 32'd1);
    check("t4_final", {24'd0, quotient, remainder}, {24'd0, 4'd2, 4'd2});
    check("t4_idle", 32'(busy), 32'd0);

    // 14/3 aborted by reset on its third CALC cycle
    @(negedge clk);
    start = 1'b1; dividend = 4'd14; divisor = 4'd3;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("t5_rst_outs", {26'd0, busy, done, quotient, remainder, div_by_zero},
          {26'd0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0});
    rst_n = 1'b1;
    ndone = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("t5_no_done", 32'(ndone), 32'd0);
    do_div(4'd6, 4'd4, lat, nbusy);
    check("t5_after", {24'd0, quotient, remainder}, {24'd0, 4'd1, 4'd2});

    // back-to-back: start in the first IDLE cycle after done
    do_div(4'd11, 4'd2, lat, nbusy);
    check("t6_first", {24'd0, quotient, remainder}, {24'd0, 4'd5, 4'd1});
    @(negedge clk);
    start = 1'b1; dividend = 4'd9; divisor = 4'd4;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (!done && lat < 20) begin
      check("t6_hold", {24'd0, quotient, remainder}, {24'd0, 4'd5, 4'd1});
      @(negedge clk);
      lat++;
    end
    check("t6_latency", 32'(lat), 32'd5);
    check("t6_second", {24'd0, quotient, remainder}, {24'd0, 4'd2, 4'd1});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
